// File: rtl/addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : addsub_pipe
// Brief    : Pipelined two's-complement adder/subtractor. The carry chain is
//            split into STAGES slices of grouped carry-lookahead logic, with a
//            valid/ready handshake, optional signed saturation and flags.
// Revision : 1.0 - initial release
// ============================================================================
module addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int GROUP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  // Guarded so an illegal STAGES/GROUP never divides by zero before the check fires
  localparam int S    = (STAGES > 0) ? WIDTH / STAGES : 1;
  localparam int NGRP = (GROUP > 0) ? S / GROUP : 1;
  localparam int LAST = STAGES - 1;

  generate
    if (STAGES < 1 || GROUP < 1 || (WIDTH % STAGES) != 0 ||
        (S % GROUP) != 0 || S < GROUP) begin : g_bad_params
      $error("addsub_pipe: illegal WIDTH/STAGES/GROUP combination");
    end
  endgenerate

  // Effective operand B and carry-in chosen once, at acceptance
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Stage registers: full-width operand copies; slice k only consumes its bits
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic             sat_q [STAGES];
  logic [STAGES-1:0] v_q;

  // Per-stage inputs (stage 0 fed from the ports, stage k from register k-1)
  logic [WIDTH-1:0] x_a   [STAGES];
  logic [WIDTH-1:0] x_b   [STAGES];
  logic [WIDTH-1:0] x_s   [STAGES];
  logic             x_c   [STAGES];
  logic             x_sat [STAGES];
  logic             x_v   [STAGES];

  // Per-stage slice results
  logic [WIDTH-1:0] n_s [STAGES];
  logic             n_c [STAGES];
  logic             c_msb;

  // Final-stage saturation and handshake
  logic             f_ovf;
  logic [WIDTH-1:0] f_res;
  logic [STAGES-1:0] ld;

  // Map op code to effective B and carry-in (cin only matters for op 1x)
  always_comb begin
    b_eff   = op[0] ? ~b : b;
    cin_eff = op[1] ? cin : op[0];
  end

  // Route each stage's operands: ports into stage 0, previous register otherwise
  always_comb begin
    x_a[0]   = a;
    x_b[0]   = b_eff;
    x_s[0]   = '0;
    x_c[0]   = cin_eff;
    x_sat[0] = sat;
    x_v[0]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      x_a[k]   = a_q[k-1];
      x_b[k]   = b_q[k-1];
      x_s[k]   = s_q[k-1];
      x_c[k]   = c_q[k-1];
      x_sat[k] = sat_q[k-1];
      x_v[k]   = v_q[k-1];
    end
  end

  // Grouped lookahead per slice: group G/P give the group carry, carries ripple group to group
  always_comb begin
    logic gg;
    logic gp;
    logic cb;
    logic pb;
    logic gb;
    int   base;
    gg    = 1'b0;
    gp    = 1'b1;
    cb    = 1'b0;
    pb    = 1'b0;
    gb    = 1'b0;
    base  = 0;
    c_msb = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      n_s[k] = x_s[k];
      n_c[k] = x_c[k];
      for (int g = 0; g < NGRP; g++) begin
        base = k * S + g * GROUP;
        gg   = 1'b0;
        gp   = 1'b1;
        cb   = n_c[k];
        for (int j = 0; j < GROUP; j++) begin
          pb = x_a[k][base+j] ^ x_b[k][base+j];
          gb = x_a[k][base+j] & x_b[k][base+j];
          n_s[k][base+j] = pb ^ cb;
          if (base + j == WIDTH - 1) begin
            c_msb = cb;
          end
          cb = gb | (pb & cb);
          gg = gb | (pb & gg);
          gp = gp & pb;
        end
        n_c[k] = gg | (gp & n_c[k]);
      end
    end
  end

  // Signed overflow and clamp; a clear raw MSB under overflow means two negatives wrapped
  always_comb begin
    f_ovf = c_msb ^ n_c[LAST];
    f_res = n_s[LAST];
    if (x_sat[LAST] && f_ovf) begin
      f_res = n_s[LAST][WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                 : {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

  // Load enables, walked back from the output so bubbles collapse
  always_comb begin
    logic nxt;
    nxt = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ld[k] = !v_q[k] || nxt;
      nxt   = ld[k];
    end
  end

  assign in_ready  = rst_n && ld[0];
  assign out_valid = v_q[LAST];

  // Advance stage registers; the last stage captures the saturated result and flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          v_q[k] <= x_v[k];
          if (x_v[k]) begin
            a_q[k]   <= x_a[k];
            b_q[k]   <= x_b[k];
            s_q[k]   <= n_s[k];
            c_q[k]   <= n_c[k];
            sat_q[k] <= x_sat[k];
          end
        end
      end
      if (ld[LAST] && x_v[LAST]) begin
        result <= f_res;
        cout   <= n_c[LAST];
        ovf    <= f_ovf;
        zero   <= (f_res == '0);
        neg    <= f_res[WIDTH-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_pipe
// Brief    : Directed vector table plus backpressure / reset sequences on an
//            8-bit, 2-stage instance; randomized sweep on a 16-bit 4-stage one.
// Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_pipe;

  localparam int W  = 8;
  localparam int RW = 16;
  localparam int NS = 300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 8-bit, 2-stage, GROUP=2 instance
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic [1:0]   op;
  logic         cin, sat, cout, ovf, zero, neg;

  addsub_pipe #(.WIDTH(W), .STAGES(2), .GROUP(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  // 16-bit, 4-stage, GROUP=4 instance for the random sweep
  logic          sw_in_valid, sw_in_ready, sw_out_valid, sw_out_ready;
  logic [RW-1:0] sw_a, sw_b, sw_result;
  logic [1:0]    sw_op;
  logic          sw_cin, sw_sat, sw_cout, sw_ovf, sw_zero, sw_neg;

  addsub_pipe #(.WIDTH(RW), .STAGES(4), .GROUP(4)) dut_sw (
    .clk(clk), .rst_n(rst_n),
    .in_valid(sw_in_valid), .in_ready(sw_in_ready),
    .a(sw_a), .b(sw_b), .op(sw_op), .cin(sw_cin), .sat(sw_sat),
    .out_valid(sw_out_valid), .out_ready(sw_out_ready),
    .result(sw_result), .cout(sw_cout), .ovf(sw_ovf), .zero(sw_zero), .neg(sw_neg)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; carry into MSB from the low WIDTH-1 bits
  function automatic logic [RW+3:0] model(input logic [RW-1:0] ma, input logic [RW-1:0] mb,
                                          input logic [1:0] mop, input logic mci, input logic mst);
    logic [RW-1:0] be;
    logic          c0;
    logic [RW:0]   full;
    logic [RW-1:0] low;
    logic          cm, co, ov;
    logic [RW-1:0] r;
    be   = mop[0] ? ~mb : mb;
    c0   = mop[1] ? mci : mop[0];
    full = {1'b0, ma} + {1'b0, be} + {{RW{1'b0}}, c0};
    low  = {1'b0, ma[RW-2:0]} + {1'b0, be[RW-2:0]} + {{(RW-1){1'b0}}, c0};
    cm   = low[RW-1];
    co   = full[RW];
    ov   = cm ^ co;
    r    = full[RW-1:0];
    if (mst && ov) r = r[RW-1] ? {1'b0, {(RW-1){1'b1}}} : {1'b1, {(RW-1){1'b0}}};
    return {r, co, ov, (r == '0), r[RW-1]};
  endfunction

  typedef struct {
    logic [W-1:0] va, vb;
    logic [1:0]   vop;
    logic         vcin, vsat;
    logic [W-1:0] res;
    logic         co, ov, z, n;
  } vec_t;

  vec_t tv [15];

  logic [RW+3:0] sbq [$];
  logic [W-1:0]  got [4];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, nrx, lat, guard, nout, at_cyc, sent, rcvd;
    logic [W-1:0] first_val;
    logic [RW+3:0] exp_sw;

    //          a      b      op     cin   sat   res    co    ov    z     n
    tv[0]  = '{8'hFF, 8'h01, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[1]  = '{8'h7F, 8'h01, 2'b00, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[2]  = '{8'h7F, 8'h01, 2'b00, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[3]  = '{8'h6C, 8'hCA, 2'b01, 1'b0, 1'b0, 8'hA2, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[4]  = '{8'h80, 8'h01, 2'b01, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1};
    tv[5]  = '{8'h05, 8'h03, 2'b11, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{8'h10, 8'h20, 2'b10, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{8'h80, 8'h80, 2'b10, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1};
    tv[8]  = '{8'h05, 8'h05, 2'b01, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[9]  = '{8'h01, 8'h01, 2'b00, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[10] = '{8'h05, 8'h03, 2'b11, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[11] = '{8'h90, 8'h10, 2'b00, 1'b0, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[12] = '{8'hC0, 8'hC0, 2'b00, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1};
    tv[13] = '{8'h7F, 8'h80, 2'b01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[14] = '{8'h00, 8'h00, 2'b01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0; cin = 1'b0; sat = 1'b0;
    sw_in_valid = 1'b0; sw_out_ready = 1'b1; sw_a = '0; sw_b = '0; sw_op = '0;
    sw_cin = 1'b0; sw_sat = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_fields", {result, cout, ovf, zero, neg}, '0);
    rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // Directed table, one beat at a time, checking latency and all fields
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1; a = tv[i].va; b = tv[i].vb; op = tv[i].vop;
      cin = tv[i].vcin; sat = tv[i].vsat;
      #1;
      guard = 0;
      while (!in_ready && guard < 20) begin
        @(negedge clk); #1; guard++;
      end
      check($sformatf("vec%0d_accept", i), in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
        @(negedge clk); lat++;
      end
      check($sformatf("vec%0d_latency", i), lat, 2);
      check($sformatf("vec%0d_out", i), {result, cout, ovf, zero, neg},
            {tv[i].res, tv[i].co, tv[i].ov, tv[i].z, tv[i].n});
    end
    @(negedge clk);

    // Backpressure: capacity of two, stalled output held, FIFO order on release
    acc = 0; nrx = 0;
    for (int cyc = 0; cyc < 30 && nrx < 4; cyc++) begin
      out_ready = (cyc >= 6);
      in_valid = (acc < 4);
      a = W'(acc + 1); b = W'(acc + 1); op = 2'b00; cin = 1'b0; sat = 1'b0;
      #1;
      if (cyc == 3) check("bp_hold_early", {out_valid, result}, {1'b1, 8'h02});
      if (cyc == 5) begin
        check("bp_accepts", acc, 2);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_hold", {out_valid, result}, {1'b1, 8'h02});
      end
      if (out_valid && out_ready) begin
        got[nrx] = result;
        nrx++;
      end
      if (in_valid && in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp_count", nrx, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < nrx) check($sformatf("bp_out%0d", i), got[i], W'(2 * (i + 1)));
    end
    @(negedge clk);

    // Reset with two beats in flight, then one fresh beat
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'h01; b = 8'h01; op = 2'b00; cin = 1'b0; sat = 1'b0;
    @(negedge clk);
    a = 8'h02; b = 8'h02;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_fields", {result, cout, ovf, zero, neg}, '0);
    check("midrst_in_ready", in_ready, 1'b0);
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; a = 8'h10; b = 8'h20;
    #1;
    check("midrst_release_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    nout = 0; at_cyc = 0; first_val = '0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      if (out_valid) begin
        if (nout == 0) begin
          first_val = result;
          at_cyc = cyc;
        end
        nout++;
      end
      @(negedge clk);
    end
    check("midrst_beats", nout, 1);
    check("midrst_value", first_val, 8'h30);
    check("midrst_latency", at_cyc, 2);

    // Random sweep on the 16-bit 4-stage instance with random backpressure
    sent = 0; rcvd = 0;
    for (int cyc = 0; cyc < 6000 && (sent < NS || sbq.size() > 0); cyc++) begin
      sw_out_ready = ($urandom_range(0, 3) != 0);
      sw_in_valid  = (sent < NS) && ($urandom_range(0, 3) != 0);
      sw_a   = RW'($urandom);
      sw_b   = RW'($urandom);
      sw_op  = 2'($urandom_range(0, 3));
      sw_cin = 1'($urandom_range(0, 1));
      sw_sat = 1'($urandom_range(0, 1));
      #1;
      if (sw_out_valid && sw_out_ready) begin
        if (sbq.size() == 0) begin
          check("sweep_unexpected_beat", 1'b1, 1'b0);
        end else begin
          exp_sw = sbq.pop_front();
          check($sformatf("sweep%0d", rcvd),
                {sw_result, sw_cout, sw_ovf, sw_zero, sw_neg}, exp_sw);
        end
        rcvd++;
      end
      if (sw_in_valid && sw_in_ready) begin
        sbq.push_back(model(sw_a, sw_b, sw_op, sw_cin, sw_sat));
        sent++;
      end
      @(negedge clk);
    end
    sw_in_valid = 1'b0;
    check("sweep_sent", sent, NS);
    check("sweep_received", rcvd, NS);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
